// File: rtl/chase_routine.sv
// rtl/chase_routine.sv - LED chase animation: up/down sweeps, pass count, flash, done pulse
module chase_routine #(
  parameter int TICK_DIV    = 12500000,
  parameter int PASSES      = 3,
  parameter int FLASH_TICKS = 8
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Restart,
  output logic [46:0] Routine
);

  localparam int CW = $clog2(TICK_DIV);
  localparam int FW = (FLASH_TICKS > 1) ? $clog2(FLASH_TICKS) : 1;
  localparam logic [CW-1:0] TICK_LAST  = CW'(TICK_DIV - 1);
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_TICKS - 1);
  localparam logic [3:0]    PASS_LAST  = 4'(PASSES);
  localparam logic [6:0]    SEG_BLANK  = 7'h7F;

  typedef enum logic [2:0] {
    S_SWEEP_UP,
    S_SWEEP_DOWN,
    S_FLASH,
    S_DONE,
    S_HOLD
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [3:0]      r_pos, w_pos_nxt;
  logic [3:0]      r_pass, w_pass_nxt;
  logic [FW-1:0]   r_fcnt, w_fcnt_nxt;
  logic [CW-1:0]   r_tick_cnt;
  logic            w_tick;
  logic [3:0]      w_pass_inc;
  logic            w_done;
  logic [9:0]      w_led_red;
  logic [7:0]      w_led_grn;
  logic [6:0]      w_disp0;

  // Active-low 7-segment code, bit 0 = segment a
  function automatic logic [6:0] f_seg(input logic [3:0] v);
    case (v)
      4'd0:    f_seg = 7'b1000000;
      4'd1:    f_seg = 7'b1111001;
      4'd2:    f_seg = 7'b0100100;
      4'd3:    f_seg = 7'b0110000;
      4'd4:    f_seg = 7'b0011001;
      4'd5:    f_seg = 7'b0010010;
      4'd6:    f_seg = 7'b0000010;
      4'd7:    f_seg = 7'b1111000;
      4'd8:    f_seg = 7'b0000000;
      4'd9:    f_seg = 7'b0010000;
      default: f_seg = SEG_BLANK;
    endcase
  endfunction

  assign w_tick     = (r_tick_cnt == TICK_LAST);
  assign w_pass_inc = r_pass + 4'd1;

  // Free-running tick divider; Restart realigns it so the first tick comes a full period later
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_tick_cnt <= '0;
    end else if (Restart || w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  // State register; Restart overrides any pending transition
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_SWEEP_UP;
      r_pos   <= 4'd0;
      r_pass  <= 4'd0;
      r_fcnt  <= '0;
    end else if (Restart) begin
      r_state <= S_SWEEP_UP;
      r_pos   <= 4'd0;
      r_pass  <= 4'd0;
      r_fcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pos   <= w_pos_nxt;
      r_pass  <= w_pass_nxt;
      r_fcnt  <= w_fcnt_nxt;
    end
  end

  // Next-state logic: sweeps and flash advance on ticks, DONE lasts a single clock
  always_comb begin
    w_state_nxt = r_state;
    w_pos_nxt   = r_pos;
    w_pass_nxt  = r_pass;
    w_fcnt_nxt  = r_fcnt;
    case (r_state)
      S_SWEEP_UP: begin
        if (w_tick) begin
          if (r_pos == 4'd9) begin
            w_pos_nxt   = 4'd8;
            w_state_nxt = S_SWEEP_DOWN;
          end else begin
            w_pos_nxt = r_pos + 4'd1;
          end
        end
      end
      S_SWEEP_DOWN: begin
        if (w_tick) begin
          if (r_pos != 4'd0) begin
            w_pos_nxt = r_pos - 4'd1;
          end else begin
            w_pass_nxt = w_pass_inc;
            if (w_pass_inc == PASS_LAST) begin
              w_fcnt_nxt  = '0;
              w_state_nxt = S_FLASH;
            end else begin
              w_pos_nxt   = 4'd1;
              w_state_nxt = S_SWEEP_UP;
            end
          end
        end
      end
      S_FLASH: begin
        if (w_tick) begin
          if (r_fcnt == FLASH_LAST) begin
            w_state_nxt = S_DONE;
          end else begin
            w_fcnt_nxt = r_fcnt + 1'b1;
          end
        end
      end
      S_DONE:  w_state_nxt = S_HOLD;
      S_HOLD:  w_state_nxt = S_HOLD;
      default: w_state_nxt = S_SWEEP_UP;
    endcase
  end

  // Output decode purely from registered state, so Restart never reaches Routine combinationally
  always_comb begin
    w_done    = 1'b0;
    w_led_red = 10'd0;
    w_led_grn = {4'd0, r_pass};
    w_disp0   = f_seg(r_pass);
    case (r_state)
      S_SWEEP_UP,
      S_SWEEP_DOWN: w_led_red = 10'd1 << r_pos;
      S_FLASH:      w_led_red = r_fcnt[0] ? 10'd0 : 10'h3FF;
      S_DONE:       w_done    = 1'b1;
      S_HOLD: begin
        w_led_grn = 8'd0;
        w_disp0   = SEG_BLANK;
      end
      default:      w_led_red = 10'd0;
    endcase
  end

  assign Routine = {w_done, w_led_red, w_led_grn, SEG_BLANK, SEG_BLANK, SEG_BLANK, w_disp0};

endmodule

// File: tb/tb_chase_routine.sv
// tb/tb_chase_routine.sv - randomized self-checking bench for chase_routine
module tb_chase_routine;

  localparam int TD = 4;
  localparam int NP = 2;
  localparam int FT = 4;

  logic        Clock   = 1'b0;
  logic        Reset   = 1'b0;
  logic        Restart = 1'b0;
  logic [46:0] Routine;

  chase_routine #(.TICK_DIV(TD), .PASSES(NP), .FLASH_TICKS(FT)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Restart (Restart),
    .Routine (Routine)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_fail   = 0;
  int c        = 0;

  logic [9:0] f_red[$];
  int         f_pass[$];

  function automatic logic [6:0] seg(input int v);
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // One frame per tick index: what the LEDs show after that many ticks since start
  task automatic build_frames();
    f_red.push_back(10'd1);
    f_pass.push_back(0);
    for (int p = 0; p < NP; p++) begin
      for (int i = (p == 0) ? 1 : 2; i <= 9; i++) begin
        f_red.push_back(10'd1 << i);
        f_pass.push_back(p);
      end
      for (int i = 8; i >= 0; i--) begin
        f_red.push_back(10'd1 << i);
        f_pass.push_back(p);
      end
      if (p + 1 < NP) begin
        f_red.push_back(10'd2);
        f_pass.push_back(p + 1);
      end else begin
        for (int f = 0; f < FT; f++) begin
          f_red.push_back((f % 2 == 0) ? 10'h3FF : 10'h000);
          f_pass.push_back(NP);
        end
      end
    end
  endtask

  // Expected Routine after cc edges since (re)start
  function automatic logic [46:0] exp_at(input int cc);
    int k;
    k = cc / TD;
    if (k < f_red.size())
      return {1'b0, f_red[k], 8'(f_pass[k]), 21'h1FFFFF, seg(f_pass[k])};
    if (k == f_red.size() && (cc % TD) == 0)
      return {1'b1, 10'd0, 8'(NP), 21'h1FFFFF, seg(NP)};
    return {1'b0, 10'd0, 8'd0, 21'h1FFFFF, 7'h7F};
  endfunction

  task automatic step();
    logic rs;
    rs = Restart;
    @(posedge Clock);
    #1;
    if (rs) c = 0;
    else c++;
  endtask

  task automatic test_reset();
    Reset   = 1'b0;
    Restart = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    n_checks++;
    if (Routine !== exp_at(0)) begin
      n_fail++;
      $display("FAIL reset_state got=%h exp=%h", Routine, exp_at(0));
    end
    @(negedge Clock);
    Reset = 1'b1;
    c = 0;
  endtask

  task automatic test_full_run();
    int done_cnt;
    done_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (Routine[46]) done_cnt++;
      n_checks++;
      if (Routine !== exp_at(c)) begin
        n_fail++;
        $display("FAIL full_run edge=%0d got=%h exp=%h", c, Routine, exp_at(c));
      end
    end
    n_checks++;
    if (done_cnt !== 1) begin
      n_fail++;
      $display("FAIL done_pulse_count got=%0d exp=1", done_cnt);
    end
  endtask

  task automatic restart_now();
    Restart = 1'b1;
    step();
    Restart = 1'b0;
    n_checks++;
    if (Routine !== exp_at(0)) begin
      n_fail++;
      $display("FAIL restart_values got=%h exp=%h", Routine, exp_at(0));
    end
  endtask

  task automatic run_checked(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      step();
      n_checks++;
      if (Routine !== exp_at(c)) begin
        n_fail++;
        $display("FAIL %s edge=%0d got=%h exp=%h", tag, c, Routine, exp_at(c));
      end
    end
  endtask

  task automatic test_restart_sweep_down();
    for (int it = 0; it < 4; it++) begin
      restart_now();
      run_checked($urandom_range(41, 71), "sweep_down_run");
      restart_now();
      run_checked(6, "restart_first_tick");
    end
  endtask

  task automatic test_random_restart();
    for (int it = 0; it < 8; it++) begin
      run_checked($urandom_range(1, 220), "random_run");
      restart_now();
    end
  endtask

  task automatic test_async_reset();
    for (int it = 0; it < 4; it++) begin
      restart_now();
      run_checked((it == 3) ? 164 : $urandom_range(148, 163), "pre_async");
      #3;
      Reset = 1'b0;
      #1;
      n_checks++;
      if (Routine !== exp_at(0)) begin
        n_fail++;
        $display("FAIL async_reset got=%h exp=%h", Routine, exp_at(0));
      end
      repeat (2) begin
        @(posedge Clock);
        #1;
        n_checks++;
        if (Routine !== exp_at(0)) begin
          n_fail++;
          $display("FAIL async_hold got=%h exp=%h", Routine, exp_at(0));
        end
      end
      @(negedge Clock);
      Reset = 1'b1;
      c = 0;
      run_checked(10, "post_async");
    end
  endtask

  task automatic test_back_to_back();
    Restart = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (Routine !== exp_at(0)) begin
        n_fail++;
        $display("FAIL held_restart got=%h exp=%h", Routine, exp_at(0));
      end
    end
    Restart = 1'b0;
    run_checked(12, "after_held_restart");
  endtask

  initial begin
    build_frames();
    test_reset();
    test_full_run();
    test_restart_sweep_down();
    test_random_restart();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
